// File: rtl/capture_ctrl.sv
// rtl/capture_ctrl.sv - single-packet capture sequencer: MAC stream to SDRAM via Avalon-MM write master
// Optional irq output enabled by defining CAPTURE_IRQ_EN.
module capture_ctrl #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] ctrl,
  input  logic [N-1:0] pkt_addr,
  input  logic [N-1:0] pkt_len,
  input  logic [N-1:0] st_data,
  input  logic         st_valid,
  input  logic         st_sop,
  input  logic         st_eop,
  output logic         st_ready,
  output logic [N-1:0] m_address,
  output logic         m_write,
  output logic [N-1:0] m_writedata,
  input  logic         m_waitrequest,
  output logic [1:0]   state,
  output logic [N-1:0] captured_len,
  output logic         truncated
`ifdef CAPTURE_IRQ_EN
  ,
  output logic         irq
`endif
);

  localparam int BPW = N / 8;
  localparam int OFS = $clog2(BPW);
  localparam logic [N-1:0] BPW_N = N'(BPW);
  localparam logic [N-1:0] ALIGN_MASK = ~(N'(BPW - 1));

  localparam logic [1:0] S_IDLE    = 2'b00;
  localparam logic [1:0] S_ARMED   = 2'b01;
  localparam logic [1:0] S_CAPTURE = 2'b10;
  localparam logic [1:0] S_DONE    = 2'b11;

  logic [1:0]   state_q, state_d;
  logic         ctrl2_q, ctrl2_d;
  logic [N-1:0] base_q, base_d;
  logic [N-1:0] limit_q, limit_d;
  logic [N-1:0] offset_q, offset_d;
  logic [N-1:0] captured_len_q, captured_len_d;
  logic         truncated_q, truncated_d;
  logic         m_write_q, m_write_d;
  logic [N-1:0] m_address_q, m_address_d;
  logic [N-1:0] m_writedata_q, m_writedata_d;
  logic         drain_q, drain_d;
  logic         eop_seen_q, eop_seen_d;
  logic         abort_pend_q, abort_pend_d;

  logic start_rise;
  logic abort_req;
  logic write_done;
  logic accept;
  logic do_load;
  logic unused_ctrl_bits;

  assign unused_ctrl_bits = ^{ctrl[N-1:4], ctrl[1:0]};

  assign start_rise = ctrl[2] & ~ctrl2_q;
  assign abort_req  = ctrl[3];
  assign write_done = m_write_q & ~m_waitrequest;

  always_comb begin
    st_ready = 1'b0;
    case (state_q)
      S_ARMED:   st_ready = ~abort_pend_q;
      S_CAPTURE: st_ready = ~abort_pend_q & ~eop_seen_q & (drain_q | ~m_write_q | ~m_waitrequest);
      default:   st_ready = 1'b0;
    endcase
  end

  assign accept = st_valid & st_ready;

  always_comb begin
    state_d        = state_q;
    ctrl2_d        = ctrl[2];
    base_d         = base_q;
    limit_d        = limit_q;
    offset_d       = offset_q;
    captured_len_d = captured_len_q;
    truncated_d    = truncated_q;
    m_write_d      = m_write_q;
    m_address_d    = m_address_q;
    m_writedata_d  = m_writedata_q;
    drain_d        = drain_q;
    eop_seen_d     = eop_seen_q;
    abort_pend_d   = abort_pend_q;
    do_load        = 1'b0;

    if (abort_req | abort_pend_q) begin
      // A write already presented to the slave must be allowed to complete.
      if (m_write_q & m_waitrequest) begin
        abort_pend_d = 1'b1;
      end else begin
        state_d      = S_IDLE;
        m_write_d    = 1'b0;
        abort_pend_d = 1'b0;
        drain_d      = 1'b0;
        eop_seen_d   = 1'b0;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_rise) begin
            state_d        = S_ARMED;
            base_d         = pkt_addr & ALIGN_MASK;
            limit_d        = pkt_len & ALIGN_MASK;
            captured_len_d = '0;
            truncated_d    = 1'b0;
            offset_d       = '0;
            drain_d        = 1'b0;
            eop_seen_d     = 1'b0;
          end
        end
        S_ARMED: begin
          if (accept & st_sop) begin
            state_d = S_CAPTURE;
            if (limit_q == '0) begin
              truncated_d = 1'b1;
              drain_d     = 1'b1;
              eop_seen_d  = st_eop;
            end else begin
              do_load = 1'b1;
            end
          end
        end
        S_CAPTURE: begin
          if (write_done) begin
            m_write_d = 1'b0;
          end
          if (accept) begin
            if (drain_q) begin
              eop_seen_d = st_eop;
            end else begin
              do_load = 1'b1;
            end
          end
          if (eop_seen_q & (~m_write_q | write_done)) begin
            state_d   = S_DONE;
            m_write_d = 1'b0;
          end
        end
        default: begin
          if (~ctrl[2]) begin
            state_d = S_IDLE;
          end
        end
      endcase
    end

    if (do_load) begin
      m_write_d      = 1'b1;
      m_writedata_d  = st_data;
      m_address_d    = base_q + (offset_q << OFS);
      offset_d       = offset_q + 1'b1;
      captured_len_d = captured_len_q + BPW_N;
      if (st_eop) begin
        eop_seen_d = 1'b1;
      end else if (captured_len_q + BPW_N == limit_q) begin
        // Limit reached mid-packet: swallow the rest of the packet.
        drain_d     = 1'b1;
        truncated_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      ctrl2_q        <= 1'b0;
      base_q         <= '0;
      limit_q        <= '0;
      offset_q       <= '0;
      captured_len_q <= '0;
      truncated_q    <= 1'b0;
      m_write_q      <= 1'b0;
      m_address_q    <= '0;
      m_writedata_q  <= '0;
      drain_q        <= 1'b0;
      eop_seen_q     <= 1'b0;
      abort_pend_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      ctrl2_q        <= ctrl2_d;
      base_q         <= base_d;
      limit_q        <= limit_d;
      offset_q       <= offset_d;
      captured_len_q <= captured_len_d;
      truncated_q    <= truncated_d;
      m_write_q      <= m_write_d;
      m_address_q    <= m_address_d;
      m_writedata_q  <= m_writedata_d;
      drain_q        <= drain_d;
      eop_seen_q     <= eop_seen_d;
      abort_pend_q   <= abort_pend_d;
    end
  end

`ifdef CAPTURE_IRQ_EN
  logic irq_q, irq_d;

  assign irq_d = (state_d == S_DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign irq = irq_q;
`endif

  assign state        = state_q;
  assign captured_len = captured_len_q;
  assign truncated    = truncated_q;
  assign m_write      = m_write_q;
  assign m_address    = m_address_q;
  assign m_writedata  = m_writedata_q;

endmodule
